// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the FIFO: consumer handshake, write-pointer input and RAM read port.
interface fifo_rd_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    // Standard mode: rd_en requests a word and rd_valid marks it one cycle later.
    // FWFT mode: rd_valid marks a presented word and rd_en in the same cycle pops it.
    logic              rd_en;
    logic              flush;
    logic [ADDR_W:0]   wr_ptr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              almost_empty;
    logic [ADDR_W:0]   rd_count;
    logic              underflow;

    modport slave (
        input  rd_en, flush, wr_ptr, ram_rd_data,
        output ram_rd_en, rd_addr, rd_ptr, rd_data, rd_valid,
               empty, almost_empty, rd_count, underflow
    );

    modport master (
        output rd_en, flush, wr_ptr, ram_rd_data,
        input  ram_rd_en, rd_addr, rd_ptr, rd_data, rd_valid,
               empty, almost_empty, rd_count, underflow
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the single-clock FIFO: wrap-bit read pointer for any depth,
// occupancy flags, sticky underflow, standard or first-word-fall-through output.
module fifo_rd_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 150,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    fifo_rd_ctrl_if.slave     bus,
    output logic [1:0]        dbg_state
);
    localparam int PW = ADDR_W + 1;
    localparam logic [ADDR_W:0]   DEPTH_P  = PW'(DEPTH);
    localparam logic [ADDR_W:0]   AE_P     = PW'(AE_THRESH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              underflow_q, underflow_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic [ADDR_W-1:0] r_idx, w_idx;
    logic              ram_empty;
    logic [ADDR_W:0]   ram_cnt;
    logic [ADDR_W:0]   ptr_inc;
    logic              ram_rd_en_c;
    logic              empty_c;
    logic [ADDR_W:0]   count_c;

    assign r_idx     = rd_ptr_q[ADDR_W-1:0];
    assign w_idx     = bus.wr_ptr[ADDR_W-1:0];
    assign ram_empty = (bus.wr_ptr == rd_ptr_q);

    // Depth need not be a power of two, so the wrapped case adds back DEPTH explicitly.
    always_comb begin
        if (bus.wr_ptr[ADDR_W] == rd_ptr_q[ADDR_W]) begin
            ram_cnt = {1'b0, w_idx} - {1'b0, r_idx};
        end else begin
            ram_cnt = DEPTH_P - {1'b0, r_idx} + {1'b0, w_idx};
        end
    end

    always_comb begin
        if (r_idx == LAST_IDX) begin
            ptr_inc = {~rd_ptr_q[ADDR_W], {ADDR_W{1'b0}}};
        end else begin
            ptr_inc = {rd_ptr_q[ADDR_W], r_idx + 1'b1};
        end
    end

    always_comb begin
        ram_rd_en_c = 1'b0;
        state_d     = state_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        empty_c     = ram_empty;
        count_c     = ram_cnt;
        if (FWFT == 0) begin
            ram_rd_en_c = bus.rd_en & ~ram_empty & ~bus.flush;
            rd_valid_d  = ram_rd_en_c;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!ram_empty) begin
                        ram_rd_en_c = 1'b1;
                        state_d     = S_WAIT;
                    end
                end
                S_WAIT: begin
                    rd_data_d = bus.ram_rd_data;
                    state_d   = S_HOLD;
                end
                S_HOLD: begin
                    if (bus.rd_en) begin
                        if (!ram_empty) begin
                            ram_rd_en_c = 1'b1;
                            state_d     = S_WAIT;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
            // Flush drops an in-flight RAM word and never starts a new fetch.
            if (bus.flush) begin
                ram_rd_en_c = 1'b0;
                state_d     = S_IDLE;
                rd_data_d   = rd_data_q;
            end
            rd_valid_d = (state_d == S_HOLD);
            empty_c    = ~rd_valid_q;
            count_c    = ram_cnt + {{ADDR_W{1'b0}}, (state_q != S_IDLE)};
        end
    end

    always_comb begin
        underflow_d = underflow_q | (bus.rd_en & empty_c);
        rd_ptr_d    = rd_ptr_q;
        if (bus.flush) begin
            underflow_d = 1'b0;
            rd_ptr_d    = bus.wr_ptr;
        end else if (ram_rd_en_c) begin
            rd_ptr_d = ptr_inc;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= rd_valid_d;
            underflow_q <= underflow_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign bus.ram_rd_en    = ram_rd_en_c;
    assign bus.rd_addr      = r_idx;
    assign bus.rd_ptr       = rd_ptr_q;
    assign bus.rd_data      = (FWFT != 0) ? rd_data_q : bus.ram_rd_data;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.empty        = empty_c;
    assign bus.almost_empty = (count_c <= AE_P);
    assign bus.rd_count     = count_c;
    assign bus.underflow    = underflow_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a standard and an FWFT instance share stimulus and are both
// compared every cycle against a word-queue model of the FIFO read side.
module tb_fifo_rd_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 150;
    localparam int AE     = 4;

    logic clk;
    logic rst_n;
    logic [1:0] dbg_s, dbg_f;

    fifo_rd_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_s ();
    fifo_rd_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_f ();

    fifo_rd_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .AE_THRESH(AE), .FWFT(0))
        u_std (.rd_clk(clk), .rd_rst_n(rst_n), .bus(if_s), .dbg_state(dbg_s));
    fifo_rd_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .AE_THRESH(AE), .FWFT(1))
        u_fwft (.rd_clk(clk), .rd_rst_n(rst_n), .bus(if_f), .dbg_state(dbg_f));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // bench-side RAM and scoreboard state
    logic [DATA_W-1:0] mem [0:255];
    logic [DATA_W-1:0] exp_q_std[$];
    logic [DATA_W-1:0] exp_q_fwft[$];
    int n_vec  = 0;
    int n_fail = 0;
    int wn     = 0;
    int rn_s   = 0;
    int rn_f   = 0;
    bit valid_s, uf_s, hold_f, infl_f, uf_f;
    logic [DATA_W-1:0] pend_s, pend_f, held_f;

    function automatic logic [ADDR_W:0] enc(input int n);
        if (n >= DEPTH) return (ADDR_W+1)'((1 << ADDR_W) + n - DEPTH);
        return (ADDR_W+1)'(n);
    endfunction

    function automatic int cnt(input int w, input int r);
        return (w - r + 2 * DEPTH) % (2 * DEPTH);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (if_s.ram_rd_en) if_s.ram_rd_data <= mem[if_s.rd_addr];
        if (if_f.ram_rd_en) if_f.ram_rd_data <= mem[if_f.rd_addr];
    end

    // Reference model: absolute word positions modulo 2*DEPTH and queues of stored words.
    always @(posedge clk) begin
        int  c;
        bit  en, pop, nh;
        if (!rst_n) begin
            rn_s = 0; rn_f = 0; valid_s = 0; uf_s = 0; hold_f = 0; infl_f = 0; uf_f = 0;
            exp_q_std.delete();
            exp_q_fwft.delete();
        end else begin
            c  = cnt(wn, rn_s);
            en = if_s.rd_en && c > 0 && !if_s.flush;
            uf_s = if_s.flush ? 1'b0 : (uf_s | (if_s.rd_en && c == 0));
            if (if_s.flush) begin
                rn_s = wn; valid_s = 0; exp_q_std.delete();
            end else if (en) begin
                pend_s = exp_q_std.pop_front(); rn_s = (rn_s + 1) % (2 * DEPTH); valid_s = 1;
            end else begin
                valid_s = 0;
            end

            c   = cnt(wn, rn_f);
            pop = hold_f && if_f.rd_en && !if_f.flush;
            en  = !if_f.flush && c > 0 && ((!hold_f && !infl_f) || pop);
            uf_f = if_f.flush ? 1'b0 : (uf_f | (if_f.rd_en && !hold_f));
            if (if_f.flush) begin
                rn_f = wn; hold_f = 0; infl_f = 0; exp_q_fwft.delete();
            end else begin
                nh = infl_f ? 1'b1 : (hold_f && !pop);
                if (infl_f) held_f = pend_f;
                if (en) begin
                    pend_f = exp_q_fwft.pop_front(); rn_f = (rn_f + 1) % (2 * DEPTH);
                end
                infl_f = en;
                hold_f = nh;
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        int c;
        if (rst_n) begin
            c = cnt(wn, rn_s);
            check("s_ram_rd_en", if_s.ram_rd_en, if_s.rd_en && c > 0 && !if_s.flush);
            check("s_rd_ptr", if_s.rd_ptr, enc(rn_s));
            check("s_rd_addr", if_s.rd_addr, enc(rn_s) & 9'h0ff);
            check("s_rd_valid", if_s.rd_valid, valid_s);
            if (valid_s) check("s_rd_data", if_s.rd_data, pend_s);
            check("s_empty", if_s.empty, c == 0);
            check("s_almost_empty", if_s.almost_empty, c <= AE);
            check("s_rd_count", if_s.rd_count, c);
            check("s_underflow", if_s.underflow, uf_s);

            c = cnt(wn, rn_f);
            check("f_ram_rd_en", if_f.ram_rd_en,
                  !if_f.flush && c > 0 && ((!hold_f && !infl_f) || (hold_f && if_f.rd_en)));
            check("f_rd_ptr", if_f.rd_ptr, enc(rn_f));
            check("f_rd_valid", if_f.rd_valid, hold_f);
            if (hold_f) check("f_rd_data", if_f.rd_data, held_f);
            check("f_empty", if_f.empty, !hold_f);
            c = c + ((hold_f || infl_f) ? 1 : 0);
            check("f_rd_count", if_f.rd_count, c);
            check("f_almost_empty", if_f.almost_empty, c <= AE);
            check("f_underflow", if_f.underflow, uf_f);
        end
    end

    // driver tasks
    task automatic push_word(input logic [DATA_W-1:0] d);
        mem[enc(wn) & 9'h0ff] = d;
        exp_q_std.push_back(d);
        exp_q_fwft.push_back(d);
        wn = (wn + 1) % (2 * DEPTH);
        if_s.wr_ptr = enc(wn);
        if_f.wr_ptr = enc(wn);
    endtask

    // One cycle: drive inputs just after the edge, return at the following negedge.
    task automatic cyc(input bit en, input bit fl, input bit wr, input logic [DATA_W-1:0] d);
        @(posedge clk);
        #1;
        if_s.rd_en = en; if_f.rd_en = en;
        if_s.flush = fl; if_f.flush = fl;
        if (wr && cnt(wn, rn_s) < DEPTH && cnt(wn, rn_f) < DEPTH) push_word(d);
        @(negedge clk);
    endtask

    task automatic settle();
        cyc(0, 1, 0, '0);
        cyc(0, 0, 0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        if_s.rd_en = 0; if_s.flush = 0; if_s.wr_ptr = '0;
        if_f.rd_en = 0; if_f.flush = 0; if_f.wr_ptr = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // reset state
        check("t1_empty", if_s.empty, 1);
        check("t1_almost_empty", if_s.almost_empty, 1);
        check("t1_rd_count", if_s.rd_count, 0);
        check("t1_rd_valid", if_s.rd_valid, 0);
        check("t1_underflow", if_s.underflow, 0);
        check("t1_f_rd_valid", if_f.rd_valid, 0);

        // standard read of three words
        cyc(0, 0, 1, 8'hA0); cyc(0, 0, 1, 8'hA1); cyc(0, 0, 1, 8'hA2);
        check("t2_count3", if_s.rd_count, 3);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, '0);
            check("t2_ram_rd_en", if_s.ram_rd_en, 1);
            check("t2_rd_addr", if_s.rd_addr, i);
            check("t2_rd_valid", if_s.rd_valid, i > 0);
            if (i > 0) check("t2_rd_data", if_s.rd_data, 8'hA0 + i - 1);
        end
        cyc(0, 0, 0, '0);
        check("t2_last_valid", if_s.rd_valid, 1);
        check("t2_last_data", if_s.rd_data, 8'hA2);
        check("t2_empty_after", if_s.empty, 1);
        settle();

        // underflow is sticky until flush
        cyc(1, 0, 0, '0);
        check("t4_no_fetch", if_s.ram_rd_en, 0);
        cyc(0, 0, 0, '0);
        check("t4_uf_set", if_s.underflow, 1);
        check("t4_f_uf_set", if_f.underflow, 1);
        check("t4_ptr_same", if_s.rd_ptr, 9'h003);
        cyc(0, 0, 0, '0);
        check("t4_uf_sticky", if_s.underflow, 1);
        settle();
        check("t4_uf_clear", if_s.underflow, 0);
        check("t4_f_uf_clear", if_f.underflow, 0);

        // pointer wrap at idx DEPTH-1
        for (int k = 0; k < 300 && wn != DEPTH - 1; k++) cyc(0, 0, 1, 8'($urandom));
        settle();
        cyc(0, 0, 1, 8'hB0); cyc(0, 0, 1, 8'hB1); cyc(0, 0, 1, 8'hB2);
        check("t3_rd_ptr_pre", if_s.rd_ptr, 9'h095);
        check("t3_wr_ptr", if_s.wr_ptr, 9'h102);
        check("t3_count3", if_s.rd_count, 3);
        cyc(1, 0, 0, '0);
        check("t3_addr149", if_s.rd_addr, 8'd149);
        cyc(0, 0, 0, '0);
        check("t3_rd_ptr_wrap", if_s.rd_ptr, 9'h100);
        check("t3_count2", if_s.rd_count, 2);
        check("t3_rd_data", if_s.rd_data, 8'hB0);
        settle();

        // FWFT fall-through and pop bubble
        cyc(0, 0, 1, 8'h55);
        check("t5_fetch", if_f.ram_rd_en, 1);
        check("t5_valid0", if_f.rd_valid, 0);
        cyc(0, 0, 1, 8'h66);
        check("t5_wait", if_f.rd_valid, 0);
        cyc(1, 0, 0, '0);
        check("t5_valid1", if_f.rd_valid, 1);
        check("t5_word0", if_f.rd_data, 8'h55);
        check("t5_count", if_f.rd_count, 2);
        check("t5_refetch", if_f.ram_rd_en, 1);
        cyc(0, 0, 0, '0);
        check("t5_bubble", if_f.rd_valid, 0);
        cyc(0, 0, 0, '0);
        check("t5_valid2", if_f.rd_valid, 1);
        check("t5_word1", if_f.rd_data, 8'h66);
        settle();

        // FWFT flush while a fetch is in flight
        cyc(0, 0, 1, 8'h77);
        cyc(0, 1, 0, '0);
        cyc(0, 0, 0, '0);
        check("t6_valid", if_f.rd_valid, 0);
        check("t6_ptr", if_f.rd_ptr, if_f.wr_ptr);
        check("t6_count", if_f.rd_count, 0);
        cyc(0, 0, 0, '0);
        check("t6_valid_later", if_f.rd_valid, 0);

        // random traffic
        for (int k = 0; k < 600; k++)
            cyc($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 55, 8'($urandom));

        // asynchronous reset mid-cycle
        cyc(0, 0, 1, 8'h99);
        cyc(0, 0, 0, '0);
        #2;
        rst_n = 1'b0;
        wn = 0;
        if_s.wr_ptr = '0; if_f.wr_ptr = '0;
        if_s.rd_en = 0; if_f.rd_en = 0; if_s.flush = 0; if_f.flush = 0;
        #1;
        check("t6_rst_f_valid", if_f.rd_valid, 0);
        check("t6_rst_f_data", if_f.rd_data, 0);
        check("t6_rst_f_ptr", if_f.rd_ptr, 0);
        check("t6_rst_f_count", if_f.rd_count, 0);
        check("t6_rst_s_ptr", if_s.rd_ptr, 0);
        check("t6_rst_s_uf", if_s.underflow, 0);
        check("t6_rst_s_empty", if_s.empty, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // fill-heavy traffic to reach the full boundary
        for (int k = 0; k < 500; k++)
            cyc($urandom_range(0, 99) < 25, $urandom_range(0, 999) < 3,
                $urandom_range(0, 99) < 75, 8'($urandom));
        for (int k = 0; k < 400; k++)
            cyc($urandom_range(0, 99) < 70, 1'b0, $urandom_range(0, 99) < 30, 8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
